// File: rtl/dwc_parallelwindow_gather.sv
// ---------------------------------------------------------------------------
// dwc_parallelwindow_gather
//
// Collects a folded stream of SIMD x PE activation tiles and reassembles one
// full KERNEL_PROD x CHANNELS window, emitted as a single wide beat.
// Tile order is NF index outer, SF index inner. Tile (nf, sf) element [s][p]
// lands in window element [kp = nf*PE + p][ch = sf*SIMD + s].
//
// Ports
//   ap_clk                clock, rising edge
//   ap_rst_n              asynchronous active-low reset
//   s_axis_input_tdata    tile, element [s][p] at bit (s*PE+p)*ACTIVATION_WIDTH
//   s_axis_input_tvalid   tile valid
//   s_axis_input_tready   tile ready
//   m_axis_output_tdata   window, element [kp][ch] at bit (kp*CHANNELS+ch)*ACTIVATION_WIDTH
//   m_axis_output_tvalid  window valid
//   m_axis_output_tready  downstream ready
//
// Build option
//   DWC_GATHER_SKID_EN    when defined, a separate output register holds the
//                         emitted window so the next window can be assembled
//                         while the current one is stalled (BEATS cycles per
//                         window instead of BEATS+1).
//
// State  | meaning
// -------+-----------------------------------------------------------------
// FILL   | no complete window held; tiles are being collected
// FULL   | a complete window is presented on the output
// ---------------------------------------------------------------------------
module dwc_parallelwindow_gather #(
    parameter int SIMD             = 3,
    parameter int PE               = 2,
    parameter int CHANNELS         = 9,
    parameter int KERNEL_PROD      = 4,
    parameter int ACTIVATION_WIDTH = 4
) (
    input  logic                                           ap_clk,
    input  logic                                           ap_rst_n,
    input  logic [SIMD*PE*ACTIVATION_WIDTH-1:0]            s_axis_input_tdata,
    input  logic                                           s_axis_input_tvalid,
    output logic                                           s_axis_input_tready,
    output logic [KERNEL_PROD*CHANNELS*ACTIVATION_WIDTH-1:0] m_axis_output_tdata,
    output logic                                           m_axis_output_tvalid,
    input  logic                                           m_axis_output_tready
);

    localparam int SF    = CHANNELS / SIMD;
    localparam int NF    = KERNEL_PROD / PE;
    localparam int AW    = ACTIVATION_WIDTH;
    localparam int WW    = KERNEL_PROD * CHANNELS * AW;
    localparam int SFW   = (SF > 1) ? $clog2(SF) : 1;
    localparam int NFW   = (NF > 1) ? $clog2(NF) : 1;

    if ((CHANNELS % SIMD) != 0 || (KERNEL_PROD % PE) != 0) begin : g_param_err
        $error("dwc_parallelwindow_gather: CHANNELS must be a multiple of SIMD and KERNEL_PROD a multiple of PE");
    end

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t           state_q;
    logic             in_rdy_q;
    logic             out_vld_q;
    logic [SFW-1:0]   sf_cnt_q;
    logic [NFW-1:0]   nf_cnt_q;
    logic [WW-1:0]    asm_q;
    logic [WW-1:0]    asm_d;
    logic             last_tile;
    logic             accept;

    assign last_tile = (sf_cnt_q == SFW'(SF - 1)) && (nf_cnt_q == NFW'(NF - 1));

    // Assembly register with the current tile merged into its slice.
    always_comb begin
        asm_d = asm_q;
        for (int s = 0; s < SIMD; s++) begin
            for (int p = 0; p < PE; p++) begin
                asm_d[((int'(nf_cnt_q) * PE + p) * CHANNELS + int'(sf_cnt_q) * SIMD + s) * AW +: AW] =
                    s_axis_input_tdata[(s * PE + p) * AW +: AW];
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            sf_cnt_q <= '0;
            nf_cnt_q <= '0;
        end else if (accept) begin
            if (sf_cnt_q == SFW'(SF - 1)) begin
                sf_cnt_q <= '0;
                if (nf_cnt_q == NFW'(NF - 1)) begin
                    nf_cnt_q <= '0;
                end else begin
                    nf_cnt_q <= nf_cnt_q + NFW'(1);
                end
            end else begin
                sf_cnt_q <= sf_cnt_q + SFW'(1);
            end
        end
    end

    // The assembly data needs no reset: only complete windows are presented.
    always_ff @(posedge ap_clk) begin
        if (accept) begin
            asm_q <= asm_d;
        end
    end

`ifdef DWC_GATHER_SKID_EN

    logic [WW-1:0] out_q;
    logic          drain;

    assign drain  = out_vld_q && m_axis_output_tready;
    // Only the last tile needs a free output register; earlier tiles only
    // touch the assembly register.
    assign s_axis_input_tready  = in_rdy_q && !(last_tile && out_vld_q && !m_axis_output_tready);
    assign accept               = s_axis_input_tvalid && s_axis_input_tready;
    assign m_axis_output_tvalid = out_vld_q;
    assign m_axis_output_tdata  = out_q;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q   <= FILL;
            in_rdy_q  <= 1'b0;
            out_vld_q <= 1'b0;
        end else begin
            in_rdy_q <= 1'b1;
            if (accept && last_tile) begin
                state_q   <= FULL;
                out_vld_q <= 1'b1;
            end else if (drain) begin
                state_q   <= FILL;
                out_vld_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (accept && last_tile) begin
            out_q <= asm_d;
        end
    end

`else

    assign s_axis_input_tready  = in_rdy_q;
    assign accept               = s_axis_input_tvalid && in_rdy_q;
    assign m_axis_output_tvalid = out_vld_q;
    assign m_axis_output_tdata  = asm_q;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q   <= FILL;
            in_rdy_q  <= 1'b0;
            out_vld_q <= 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    if (accept && last_tile) begin
                        state_q   <= FULL;
                        out_vld_q <= 1'b1;
                        in_rdy_q  <= 1'b0;
                    end else begin
                        // Also raises ready on the first clock after reset.
                        in_rdy_q  <= 1'b1;
                    end
                end
                FULL: begin
                    if (m_axis_output_tready) begin
                        state_q   <= FILL;
                        out_vld_q <= 1'b0;
                        in_rdy_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= FILL;
                    out_vld_q <= 1'b0;
                    in_rdy_q  <= 1'b0;
                end
            endcase
        end
    end

`endif

endmodule

// File: tb/tb_dwc_parallelwindow_gather.sv
module tb_dwc_parallelwindow_gather;

`ifdef DWC_GATHER_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;

    logic [23:0]  in_data0;
    logic         in_valid0;
    logic         in_ready0;
    logic [143:0] out_data0;
    logic         out_valid0;
    logic         out_ready0;

    logic [143:0] in_data1;
    logic         in_valid1;
    logic         in_ready1;
    logic [143:0] out_data1;
    logic         out_valid1;
    logic         out_ready1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dwc_parallelwindow_gather dut0 (
        .ap_clk               (clk),
        .ap_rst_n             (rst_n),
        .s_axis_input_tdata   (in_data0),
        .s_axis_input_tvalid  (in_valid0),
        .s_axis_input_tready  (in_ready0),
        .m_axis_output_tdata  (out_data0),
        .m_axis_output_tvalid (out_valid0),
        .m_axis_output_tready (out_ready0)
    );

    dwc_parallelwindow_gather #(
        .SIMD(9), .PE(4), .CHANNELS(9), .KERNEL_PROD(4), .ACTIVATION_WIDTH(4)
    ) dut1 (
        .ap_clk               (clk),
        .ap_rst_n             (rst_n),
        .s_axis_input_tdata   (in_data1),
        .s_axis_input_tvalid  (in_valid1),
        .s_axis_input_tready  (in_ready1),
        .m_axis_output_tdata  (out_data1),
        .m_axis_output_tvalid (out_valid1),
        .m_axis_output_tready (out_ready1)
    );

    // Window whose element [kp][ch] is (kp*9 + ch + seed) mod 16.
    function automatic logic [143:0] golden(input int seed);
        logic [143:0] g;
        g = '0;
        for (int kp = 0; kp < 4; kp++)
            for (int ch = 0; ch < 9; ch++)
                g[(kp*9+ch)*4 +: 4] = 4'(kp*9 + ch + seed);
        return g;
    endfunction

    // Tile (nf, sf) of the default instance carrying the golden values.
    function automatic logic [23:0] tile0(input int nf, input int sf, input int seed);
        logic [23:0] t;
        t = '0;
        for (int s = 0; s < 3; s++)
            for (int p = 0; p < 2; p++)
                t[(s*2+p)*4 +: 4] = 4'((nf*2+p)*9 + sf*3 + s + seed);
        return t;
    endfunction

    function automatic logic [143:0] tile1(input int seed);
        logic [143:0] t;
        t = '0;
        for (int s = 0; s < 9; s++)
            for (int p = 0; p < 4; p++)
                t[(s*4+p)*4 +: 4] = 4'(p*9 + s + seed);
        return t;
    endfunction

    task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge: drive, sample the handshake, advance one cycle.
    task automatic step0(input logic v, input logic [23:0] d, input logic r,
                         output logic acc, output logic drn, output logic vld,
                         output logic [143:0] dobs);
        in_valid0  = v;
        in_data0   = d;
        out_ready0 = r;
        #1;
        acc  = v && in_ready0;
        vld  = out_valid0;
        drn  = out_valid0 && r;
        dobs = out_data0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid0 = 1'b0;
        in_valid1 = 1'b0;
        #1;
        chk("rst_vld0", 144'(out_valid0), 144'(0));
        chk("rst_rdy0", 144'(in_ready0), 144'(0));
        chk("rst_vld1", 144'(out_valid1), 144'(0));
        @(negedge clk);
        @(negedge clk);
        chk("rst_hold_vld0", 144'(out_valid0), 144'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_rdy_after", 144'(in_ready0), 144'(1));
    endtask

    initial begin
        logic         acc, drn, vld, prev_stall, v, r;
        logic [143:0] dobs, prev_data;
        int           tin, wout, nacc, ndrn;

        rst_n      = 1'b0;
        in_valid0  = 1'b0;
        in_data0   = '0;
        out_ready0 = 1'b1;
        in_valid1  = 1'b0;
        in_data1   = '0;
        out_ready1 = 1'b1;
        @(negedge clk);

        // Single window, both sides ready.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            chk("t1_vld_fill", 144'(out_valid0), 144'(0));
            step0(1'b1, tile0(k/3, k%3, 0), 1'b1, acc, drn, vld, dobs);
            chk("t1_acc", 144'(acc), 144'(1));
        end
        chk("t1_vld", 144'(out_valid0), 144'(1));
        chk("t1_data", out_data0, golden(0));
        chk("t1_rdy_full", 144'(in_ready0), 144'(SKID));
        step0(1'b0, '0, 1'b1, acc, drn, vld, dobs);
        chk("t1_drain", 144'(drn), 144'(1));
        chk("t1_vld_one_cycle", 144'(out_valid0), 144'(0));

        // Output stalled for 20 cycles after a window completes.
        do_reset();
        for (int k = 0; k < 6; k++)
            step0(1'b1, tile0(k/3, k%3, 7), 1'b0, acc, drn, vld, dobs);
        for (int i = 0; i < 20; i++) begin
            chk("t2_vld", 144'(out_valid0), 144'(1));
            chk("t2_rdy", 144'(in_ready0), 144'(SKID));
            chk("t2_data", out_data0, golden(7));
            step0(1'b0, '0, 1'b0, acc, drn, vld, dobs);
        end
        step0(1'b0, '0, 1'b1, acc, drn, vld, dobs);
        chk("t2_release", 144'(drn), 144'(1));
        chk("t2_vld_after", 144'(out_valid0), 144'(0));
        chk("t2_rdy_after", 144'(in_ready0), 144'(1));

        // Reset in the middle of a window.
        do_reset();
        for (int k = 0; k < 3; k++)
            step0(1'b1, tile0(k/3, k%3, 3), 1'b1, acc, drn, vld, dobs);
        in_valid0 = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk("t3_rst_vld", 144'(out_valid0), 144'(0));
        chk("t3_rst_rdy", 144'(in_ready0), 144'(0));
        @(negedge clk);
        chk("t3_rst_vld2", 144'(out_valid0), 144'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("t3_rdy_after", 144'(in_ready0), 144'(1));
        for (int k = 0; k < 6; k++)
            step0(1'b1, tile0(k/3, k%3, 5), 1'b1, acc, drn, vld, dobs);
        chk("t3_vld", 144'(out_valid0), 144'(1));
        chk("t3_data", out_data0, golden(5));
        step0(1'b0, '0, 1'b1, acc, drn, vld, dobs);

        // Single-beat windows on the SIMD=9, PE=4 instance.
        do_reset();
        nacc = 0;
        ndrn = 0;
        for (int i = 0; i < 8; i++) begin
            in_valid1  = 1'b1;
            in_data1   = tile1(nacc);
            out_ready1 = 1'b1;
            #1;
            acc = in_ready1;
            if (out_valid1) begin
                chk("t4_data", out_data1, golden(ndrn));
                ndrn++;
            end
            @(posedge clk);
            @(negedge clk);
            if (acc) nacc++;
        end
        in_valid1 = 1'b0;
        chk("t4_accepts", 144'(nacc), SKID ? 144'(8) : 144'(4));
        chk("t4_windows", 144'(ndrn), SKID ? 144'(7) : 144'(4));

        // Continuous traffic, both sides ready: throughput.
        do_reset();
        tin = 0; wout = 0; nacc = 0;
        for (int c = 0; c < 36; c++) begin
            step0(1'b1, tile0((tin%6)/3, tin%3, tin/6 + 10), 1'b1, acc, drn, vld, dobs);
            if (drn) begin
                chk("t5_data", dobs, golden(wout + 10));
                wout++;
            end
            if (acc) begin
                tin++;
                nacc++;
            end
        end
        chk("t5_accepts", 144'(nacc), SKID ? 144'(36) : 144'(31));
        chk("t5_windows", 144'(wout), 144'(5));

        // Output stalled with continuous input: where input stops.
        do_reset();
        tin = 0;
        for (int c = 0; c < 20; c++) begin
            step0(1'b1, tile0((tin%6)/3, tin%3, tin/6 + 20), 1'b0, acc, drn, vld, dobs);
            if (acc) tin++;
        end
        chk("t6_accepts", 144'(tin), SKID ? 144'(11) : 144'(6));
        chk("t6_vld", 144'(out_valid0), 144'(1));
        chk("t6_data", out_data0, golden(20));

        // Random valid / ready over 50 windows.
        do_reset();
        tin = 0; wout = 0; prev_stall = 1'b0; prev_data = '0;
        for (int c = 0; c < 6000 && wout < 50; c++) begin
            v = ($urandom_range(0, 9) < 7);
            r = ($urandom_range(0, 9) < 4);
            if (prev_stall) begin
                chk("rnd_hold_vld", 144'(out_valid0), 144'(1));
                chk("rnd_hold_data", out_data0, prev_data);
            end
            step0(v, tile0((tin%6)/3, tin%3, tin/6), r, acc, drn, vld, dobs);
            if (!SKID && vld) chk("rnd_no_acc_full", 144'(acc), 144'(0));
            if (drn) begin
                chk("rnd_data", dobs, golden(wout));
                wout++;
            end
            if (acc) tin++;
            prev_stall = vld && !r;
            prev_data  = dobs;
        end
        in_valid0 = 1'b0;
        chk("rnd_windows", 144'(wout), 144'(50));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
